// File: rtl/compare_16_serial.sv
// Serial 16-bit magnitude comparator with cascade inputs.
// Compares one nibble per cycle, MSB nibble first, and stops at the first
// nibble that differs. If every nibble matches, the latched cascade inputs
// become the result unchanged. The result is offered on a valid/ready
// handshake, and completed handshakes are counted.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an operand pair; in_ready high
// S_CMP  | comparing nibble idx of the latched operands
// S_DONE | result held on FGT/FLE/FEQ; out_valid high until out_ready
module compare_16_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        IGT,
   input  logic        ILE,
   input  logic        IEQ,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        FGT,
   output logic        FLE,
   output logic        FEQ,
   output logic [15:0] cmp_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  casc_q, casc_d;
   logic [2:0]  res_q, res_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  nib_a, nib_b;

   // Pick the nibble currently under comparison.
   always_comb begin
      nib_a = a_q[3:0];
      nib_b = b_q[3:0];
      case (idx_q)
         2'd3: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
         2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
         2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
         default: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; end
      endcase
   end

   // Next-state, datapath and handshake outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      casc_d    = casc_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               casc_d  = {IGT, ILE, IEQ};
               idx_d   = 2'd3;
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            if (nib_a > nib_b) begin
               res_d   = 3'b100;
               state_d = S_DONE;
            end else if (nib_a < nib_b) begin
               res_d   = 3'b010;
               state_d = S_DONE;
            end else if (idx_q == 2'd0) begin
               // All nibbles equal: cascade passes through, even if not one-hot.
               res_d   = casc_q;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - 2'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd3;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         casc_q  <= 3'd0;
         res_q   <= 3'd0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         casc_q  <= casc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   assign FGT       = res_q[2];
   assign FLE       = res_q[1];
   assign FEQ       = res_q[0];
   assign cmp_count = cnt_q;

endmodule

// File: tb/tb_compare_16_serial.sv
module tb_compare_16_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] A = 16'd0;
   logic [15:0] B = 16'd0;
   logic        IGT = 1'b0, ILE = 1'b0, IEQ = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        FGT, FLE, FEQ;
   logic [15:0] cmp_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   compare_16_serial dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .IGT(IGT), .ILE(ILE), .IEQ(IEQ),
      .out_valid(out_valid), .out_ready(out_ready),
      .FGT(FGT), .FLE(FLE), .FEQ(FEQ),
      .cmp_count(cmp_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural reference: on accept the result and its latency are worked
   // out from whole-word arithmetic; the model then only waits n cycles.
   int          m_state = 0;   // 0 idle, 1 busy, 2 result offered
   int          m_left  = 0;
   logic [2:0]  m_pend  = 3'd0;
   logic [2:0]  m_flags = 3'd0;
   logic [15:0] m_cnt   = 16'd0;

   function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
      for (int i = 3; i >= 0; i--)
         if (a[4*i +: 4] != b[4*i +: 4]) return 4 - i;
      return 4;
   endfunction

   function automatic logic [2:0] expect_flags(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] casc);
      if (a > b) return 3'b100;
      if (a < b) return 3'b010;
      return casc;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_state = 0;
         m_flags = 3'd0;
         m_cnt   = 16'd0;
      end else begin
         case (m_state)
            0: if (in_valid) begin
                  m_left  = first_diff(A, B);
                  m_pend  = expect_flags(A, B, {IGT, ILE, IEQ});
                  m_state = 1;
               end
            1: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_flags = m_pend;
                     m_state = 2;
                  end
               end
            default: if (out_ready) begin
                  m_cnt   = m_cnt + 16'd1;
                  m_state = 0;
               end
         endcase
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model out_valid", out_valid, m_state == 2);
         chk("model in_ready", in_ready, (m_state == 0) && !rst);
         chk("model flags", {FGT, FLE, FEQ}, m_flags);
         chk("model cmp_count", cmp_count, m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pair(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] casc, input int exp_n, input logic [2:0] exp_f,
                           input int hold);
      int cyc;
      logic [2:0] f0;
      chk({nm, " in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      A = a; B = b; {IGT, ILE, IEQ} = casc;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 8) begin
         // Scramble inputs mid-compare; the latched copy must be used.
         A = 16'($urandom); B = 16'($urandom); {IGT, ILE, IEQ} = 3'($urandom);
         step();
         cyc++;
      end
      chk({nm, " latency"}, cyc, exp_n);
      chk({nm, " flags"}, {FGT, FLE, FEQ}, exp_f);
      f0 = {FGT, FLE, FEQ};
      for (int i = 0; i < hold; i++) begin
         step();
         chk({nm, " hold valid"}, out_valid, 1'b1);
         chk({nm, " hold flags"}, {FGT, FLE, FEQ}, f0);
         chk({nm, " hold in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({nm, " released"}, out_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      chk_en = 1'b1;
      rst = 1'b0;
      #1;
      chk("reset flags", {FGT, FLE, FEQ}, 3'b000);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset cmp_count", cmp_count, 16'd0);

      run_pair("msb_gt", 16'hB001, 16'h4001, 3'b001, 1, 3'b100, 0);
      chk("count after first", cmp_count, 16'd1);
      run_pair("lsb_lt", 16'h8C2E, 16'h8C2F, 3'b001, 4, 3'b010, 0);
      run_pair("nib1_gt", 16'h8C20, 16'h8C10, 3'b001, 3, 3'b100, 0);
      run_pair("eq_ieq", 16'h8C2F, 16'h8C2F, 3'b001, 4, 3'b001, 5);
      run_pair("eq_igt", 16'h8C2F, 16'h8C2F, 3'b100, 4, 3'b100, 0);
      run_pair("eq_nonhot", 16'h1234, 16'h1234, 3'b110, 4, 3'b110, 2);
      run_pair("nib2_lt", 16'h5300, 16'h5400, 3'b000, 2, 3'b010, 0);
      chk("count after seven", cmp_count, 16'd7);
      chk("idle retains flags", {FGT, FLE, FEQ}, 3'b010);

      // Abort an equal-pair comparison with reset.
      in_valid = 1'b1; A = 16'hAAAA; B = 16'hAAAA; {IGT, ILE, IEQ} = 3'b001;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("rst in_ready", in_ready, 1'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("abort no valid", out_valid, 1'b0);
         step();
      end
      chk("abort count", cmp_count, 16'd0);
      chk("abort in_ready", in_ready, 1'b1);
      run_pair("after_abort", 16'h0010, 16'h0001, 3'b000, 3, 3'b100, 0);
      chk("count after abort", cmp_count, 16'd1);

      // Randomised traffic; the compare process does the checking.
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = a;
         if ($urandom_range(0, 4) != 4) begin
            int p;
            p = $urandom_range(0, 3);
            b[4*p +: 4] = 4'($urandom);
         end
         A = a; B = b;
         {IGT, ILE, IEQ} = 3'($urandom);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/compare_16_serial.md
COMPARE_16_SERIAL -- requirements
Module: compare_16_serial

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand pair and cascade inputs are presented.
REQ-005 in_ready  output  1  block accepts a new operand pair this cycle.
REQ-006 A  input  16  unsigned operand A.
REQ-007 B  input  16  unsigned operand B.
REQ-008 IGT  input  1  cascade "greater" input from the lower-priority stage.
REQ-009 ILE  input  1  cascade "less" input from the lower-priority stage.
REQ-010 IEQ  input  1  cascade "equal" input from the lower-priority stage.
REQ-011 out_valid  output  1  FGT, FLE and FEQ hold a valid result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 FGT  output  1  A > B result, registered.
REQ-014 FLE  output  1  A < B result, registered.
REQ-015 FEQ  output  1  A = B result, registered.
REQ-016 cmp_count  output  16  number of completed result handshakes since reset, registered.

Function
REQ-017 The FSM SHALL have three states: IDLE, CMP and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE with rst low. An accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-019 On accept, the block SHALL latch A, B, IGT, ILE and IEQ, set nibble index idx to 3, and move to CMP.
REQ-020 In CMP, the block SHALL compare nibble idx (bits 4*idx+3..4*idx) of the latched A and B, giving one nibble per cycle, MSB nibble first.
REQ-021 When the nibbles are unequal, the block SHALL register FGT/FLE/FEQ at that edge as 1/0/0 if A's nibble is greater, or 0/1/0 if it is less, and move to DONE (early termination).
REQ-022 When the nibbles are equal and idx > 0, the block SHALL decrement idx and stay in CMP.
REQ-023 When the nibbles are equal and idx = 0, the block SHALL register FGT=IGT, FLE=ILE and FEQ=IEQ from the latched values, passed through unchanged even if they are not one-hot, and move to DONE.
REQ-024 Latency SHALL be: an accept at edge k gives out_valid high after edge k+n, where n (1..4) is the position of the first differing nibble counted from the MSB, and n = 4 when all nibbles are equal.
REQ-025 out_valid SHALL be 1 exactly in DONE. FGT/FLE/FEQ SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 In DONE with out_ready=1, at the next edge the block SHALL go to IDLE and increment cmp_count, which wraps from 0xFFFF to 0x0000.
REQ-027 In IDLE, FGT/FLE/FEQ SHALL retain the last result. Only out_valid qualifies them.
REQ-028 Changes to A, B and the cascade inputs after accept SHALL NOT affect the result in progress.
REQ-029 No new pair SHALL be accepted in the same cycle as the DONE->IDLE transition, so the minimum accept-to-accept spacing is n+2 cycles.

Reset
REQ-030 While rst=1 at an edge, the block SHALL set the state to IDLE, idx=3, FGT=FLE=FEQ=0, out_valid=0, cmp_count=0, and clear the latched operands.
REQ-031 in_ready SHALL be 0 in any cycle where rst=1.
REQ-032 Reset asserted in CMP or DONE SHALL abort the operation, produce no out_valid, and leave cmp_count at 0.

Verification
REQ-033 rst high 2 cycles then low -> FGT=FLE=FEQ=0, out_valid=0, in_ready=1, cmp_count=0.
REQ-034 A=0xB001, B=0x4001, IEQ=1, out_ready=1 -> out_valid one cycle after accept+1 (n=1), FGT=1, FLE=0, FEQ=0, cmp_count=1.
REQ-035 A=0x8C2E, B=0x8C2F -> n=4, FLE=1; A=0x8C20, B=0x8C10 -> n=3, FGT=1.
REQ-036 A=B=0x8C2F with IGT/ILE/IEQ=0/0/1 -> FEQ=1 after 4 CMP cycles; repeat with 1/0/0 -> FGT=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_valid and flags stable, in_ready=0. Operands changed during CMP do not alter the result.
REQ-038 rst pulsed during CMP of an equal pair -> no out_valid, state IDLE, cmp_count=0. The next pair completes normally.
